// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU (alu_seq).
// Optional feature macro used elsewhere in this slice: ALU_SEQ_CARRY_IN_EN.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_B   = 3'b000,
        ALU_LSL      = 3'b001,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110,
        ALU_LSR      = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit positions inside the architectural {N,Z,C,V} register.
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_LSL) || (op == ALU_LSR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result bus of alu_seq.
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// in_valid/out_valid, once raised by their producer, stay high with stable
// payload until the matching ready is seen. use_carry exists only when
// ALU_SEQ_CARRY_IN_EN is defined. dbg_state mirrors the FSM for observation.
interface alu_seq_if #(
    parameter int WIDTH = 64
) ();
    import alu_seq_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic [SHW-1:0]   shamt;
    logic             set_flags;
`ifdef ALU_SEQ_CARRY_IN_EN
    logic             use_carry;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic [3:0]       nzcv;
    state_t           dbg_state;

    modport master (
`ifdef ALU_SEQ_CARRY_IN_EN
        output use_carry,
`endif
        output in_valid, A, B, cntrl, shamt, set_flags, out_ready,
        input  in_ready, out_valid, result, negative, zero, overflow,
        input  carry_out, nzcv, dbg_state
    );

    modport slave (
`ifdef ALU_SEQ_CARRY_IN_EN
        input  use_carry,
`endif
        input  in_valid, A, B, cntrl, shamt, set_flags, out_ready,
        output in_ready, out_valid, result, negative, zero, overflow,
        output carry_out, nzcv, dbg_state
    );

endinterface

// File: rtl/alu_seq_core.sv
// Combinational add/sub/logic unit with per-op flag generation.
// Shift opcodes arriving here are shift-by-zero, so they pass A through.
module alu_seq_core import alu_seq_pkg::*; #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH:0]   sum;
    logic             arith;

    // Shared adder (subtract is A + ~B + carry_in), result mux and flags.
    always_comb begin
        b_opnd = (op == ALU_SUBTRACT) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, carry_in};
        arith  = (op == ALU_ADD) || (op == ALU_SUBTRACT);
        case (op)
            ALU_PASS_B:             result = b;
            ALU_ADD, ALU_SUBTRACT:  result = sum[WIDTH-1:0];
            ALU_AND:                result = a & b;
            ALU_OR:                 result = a | b;
            ALU_XOR:                result = a ^ b;
            default:                result = a;
        endcase
        carry_out = arith & sum[WIDTH];
        overflow  = arith & (a[WIDTH-1] == b_opnd[WIDTH-1])
                          & (sum[WIDTH-1] != a[WIDTH-1]);
        negative  = result[WIDTH-1];
        zero      = (result == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic, bit-serial
// LSL/LSR (one bit per cycle), and a persistent NZCV flag register.
// Optional macro ALU_SEQ_CARRY_IN_EN adds use_carry (ADC/SBC carry-in from C).
module alu_seq import alu_seq_pkg::*; #(
    parameter int WIDTH = 64
) (
    input logic      clk,
    input logic      reset,
    alu_seq_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             neg_q, neg_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, cout_q, cout_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;  // 1: shift right
    logic             sf_q, sf_d;

    alu_op_t          op_in;
    logic             in_ready, accept, out_hs, core_cin;
    logic [WIDTH-1:0] core_result, first_step, shift_step, fin_val;
    logic             core_neg, core_zero, core_ovf, core_cout, fin;

    assign op_in    = alu_op_t'(bus.cntrl);
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign out_hs   = (state_q == DONE) && bus.out_ready;

`ifdef ALU_SEQ_CARRY_IN_EN
    assign core_cin = bus.use_carry ? nzcv_q[NZCV_C] : (op_in == ALU_SUBTRACT);
`else
    assign core_cin = (op_in == ALU_SUBTRACT);
`endif

    alu_seq_core #(.WIDTH(WIDTH)) u_core (
        .a         (bus.A),
        .b         (bus.B),
        .op        (op_in),
        .carry_in  (core_cin),
        .result    (core_result),
        .negative  (core_neg),
        .zero      (core_zero),
        .overflow  (core_ovf),
        .carry_out (core_cout)
    );

    // The first bit of a shift is taken at accept so latency equals shamt.
    assign first_step = (op_in == ALU_LSR) ? (bus.A >> 1) : (bus.A << 1);
    assign shift_step = dir_q ? (shreg_q >> 1) : (shreg_q << 1);

    // Next-state, datapath capture and NZCV update.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        nzcv_d   = nzcv_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        sf_d     = sf_q;
        fin      = 1'b0;
        fin_val  = '0;

        if (out_hs) begin
            state_d = IDLE;
            if (sf_q) begin
                nzcv_d[NZCV_N] = neg_q;
                nzcv_d[NZCV_Z] = zero_q;
                nzcv_d[NZCV_C] = cout_q;
                nzcv_d[NZCV_V] = ovf_q;
            end
        end

        if (state_q == SHIFT) begin
            shreg_d = shift_step;
            cnt_d   = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                fin     = 1'b1;
                fin_val = shift_step;
            end
        end else if (accept) begin
            sf_d  = bus.set_flags;
            dir_d = (op_in == ALU_LSR);
            if (is_shift(op_in) && (bus.shamt != '0)) begin
                if (bus.shamt == SHW'(1)) begin
                    fin     = 1'b1;
                    fin_val = first_step;
                end else begin
                    state_d = SHIFT;
                    shreg_d = first_step;
                    cnt_d   = bus.shamt - SHW'(1);
                end
            end else begin
                state_d  = DONE;
                result_d = core_result;
                neg_d    = core_neg;
                zero_d   = core_zero;
                ovf_d    = core_ovf;
                cout_d   = core_cout;
            end
        end

        if (fin) begin
            state_d  = DONE;
            result_d = fin_val;
            neg_d    = fin_val[WIDTH-1];
            zero_d   = (fin_val == '0);
            ovf_d    = 1'b0;
            cout_d   = 1'b0;
        end
    end

    // State register with synchronous reset; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            nzcv_q   <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            sf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
            nzcv_q   <= nzcv_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            sf_q     <= sf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.negative  = neg_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.carry_out = cout_q;
    assign bus.nzcv      = nzcv_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops,
// expected results from an arithmetic reference model, checked by a
// scoreboard monitor. Define ALU_SEQ_CARRY_IN_EN to exercise use_carry.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W   = 64;
    localparam int SHW = 6;
    localparam logic signed [W+1:0] SMAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] SMIN = {3'b111, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;   // {N,Z,C,V}
        logic         sf;
        int           lat;
        int           acc;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [3:0]   model_nzcv = 4'b0000;
    bit           head_seen = 1'b0;
    int           rdy_mode = 1;   // 0 random, 1 high, 2 low
    int           last_acc = 0;
    logic [W-1:0] last_res = '0;
    logic [3:0]   last_flg = '0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int sh, input logic sf,
                                   input logic uc, input logic c_reg);
        exp_t e;
        logic [W+1:0]        u;
        logic signed [W+1:0] s;
        logic [W-1:0]        bo;
        logic                ci, c, v;
        c = 1'b0;
        v = 1'b0;
        e.lat = 1;
        e.acc = 0;
        e.res = '0;
        case (op)
            3'd0: e.res = b;
            3'd1: begin e.res = a << sh; if (sh > 0) e.lat = sh; end
            3'd2, 3'd3: begin
                bo = (op == 3'd3) ? ~b : b;
                ci = uc ? c_reg : (op == 3'd3);
                u  = {2'b00, a} + {2'b00, bo} + {{(W+1){1'b0}}, ci};
                e.res = u[W-1:0];
                c = (u >= {2'b01, {W{1'b0}}});
                s = $signed({{2{a[W-1]}}, a}) + $signed({{2{bo[W-1]}}, bo})
                    + $signed({{(W+1){1'b0}}, ci});
                v = (s > SMAX) || (s < SMIN);
            end
            3'd4: e.res = a & b;
            3'd5: e.res = a | b;
            3'd6: e.res = a ^ b;
            default: begin e.res = a >> sh; if (sh > 0) e.lat = sh; end
        endcase
        e.flg = {e.res[W-1], (e.res == '0), c, v};
        e.sf  = sf;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int sh, input logic sf, input logic uc);
        exp_t e;
        int   t;
        bit   ok;
        bus.in_valid  = 1'b1;
        bus.cntrl     = op;
        bus.A         = a;
        bus.B         = b;
        bus.shamt     = SHW'(sh);
        bus.set_flags = sf;
`ifdef ALU_SEQ_CARRY_IN_EN
        bus.use_carry = uc;
`endif
        ok = 1'b0;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            e = model(op, a, b, sh, sf, uc, model_nzcv[NZCV_C]);
            e.acc = cyc;
            last_acc = cyc;
            exp_q.push_back(e);
        end else begin
            fail_now("accept_timeout");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- out_ready driver ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_res = '0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            check("nzcv", {60'd0, bus.nzcv}, {60'd0, model_nzcv});
            if (prev_hold) begin
                check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
                check("hold_result", bus.result, prev_res);
            end
            if (bus.out_valid && !head_seen) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    check("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                    head_seen = 1'b1;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", bus.result, e.res);
                    check("flags", {60'd0, bus.negative, bus.zero, bus.carry_out, bus.overflow},
                          {60'd0, e.flg});
                    last_res = bus.result;
                    last_flg = {bus.negative, bus.zero, bus.carry_out, bus.overflow};
                    if (e.sf) model_nzcv = e.flg;
                end
                head_seen = 1'b0;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_res  = bus.result;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int a0, a1, a2;
        logic [W-1:0] ra;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.cntrl     = '0;
        bus.shamt     = '0;
        bus.set_flags = 1'b0;
`ifdef ALU_SEQ_CARRY_IN_EN
        bus.use_carry = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_flags", {60'd0, bus.negative, bus.zero, bus.carry_out, bus.overflow}, 64'd0);
        check("rst_nzcv", {60'd0, bus.nzcv}, 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // ADDS signed overflow
        issue(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b1, 1'b0);
        wait_drain();
        check("adds_result", last_res, 64'h8000_0000_0000_0000);
        check("adds_flags", {60'd0, last_flg}, 64'b1001);
        check("adds_nzcv", {60'd0, bus.nzcv}, 64'b1001);

        // SUB without flag update
        issue(3'd3, 64'h8000_0000_0000_0000, 64'd1, 0, 1'b0, 1'b0);
        wait_drain();
        check("sub_result", last_res, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_flags", {60'd0, last_flg}, 64'b0011);
        check("sub_nzcv_kept", {60'd0, bus.nzcv}, 64'b1001);

        // LSL by 63, with in_valid held during SHIFT (must be ignored)
        issue(3'd1, 64'd1, 64'd0, 63, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.cntrl    = 3'd0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            check("shift_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        wait_drain();
        check("lsl63_result", last_res, 64'h8000_0000_0000_0000);
        check("lsl63_nzcv", {60'd0, bus.nzcv}, 64'b1000);

        // LSR by zero passes A
        ra = {$urandom, $urandom};
        issue(3'd7, ra, 64'd0, 0, 1'b0, 1'b0);
        wait_drain();
        check("lsr0_result", last_res, ra);

        // Back-to-back AND, OR, XOR
        issue(3'd4, pick(), pick(), 0, 1'b0, 1'b0);
        a0 = last_acc;
        issue(3'd5, pick(), pick(), 0, 1'b0, 1'b0);
        a1 = last_acc;
        issue(3'd6, 64'h8000_0000_0000_0000, 64'd0, 0, 1'b1, 1'b0);
        a2 = last_acc;
        check("b2b_gap1", 64'(a1 - a0), 64'd1);
        check("b2b_gap2", 64'(a2 - a1), 64'd1);
        wait_drain();

        // Back-pressure: result held, in_ready blocked
        rdy_mode = 2;
        bus.out_ready = 1'b0;
        issue(3'd6, pick(), pick(), 0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        rdy_mode = 1;
        wait_drain();

        // Reset in the middle of a 40-bit shift
        issue(3'd1, pick() | 64'd1, 64'd0, 40, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        head_seen = 1'b0;
        model_nzcv = 4'b0000;
        @(negedge clk);
        check("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_mid_nzcv", {60'd0, bus.nzcv}, 64'd0);
        check("rst_mid_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_mid_result", bus.result, 64'd0);
        repeat (45) @(posedge clk);
        #1;

`ifdef ALU_SEQ_CARRY_IN_EN
        // ADDS producing C=1, then ADC uses it
        issue(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b1, 1'b0);
        wait_drain();
        check("adcs_nzcv", {60'd0, bus.nzcv}, 64'b0110);
        issue(3'd2, 64'd2, 64'd3, 0, 1'b0, 1'b1);
        wait_drain();
        check("adc_result", last_res, 64'd6);
`endif

        // Randomized traffic with random back-pressure
        rdy_mode = 0;
        repeat (150) begin
            int sh;
            sh = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                              : int'($urandom_range(0, 3));
            issue(3'($urandom_range(0, 7)), pick(), pick(), sh,
                  1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
